des_round_engine: RTL and testbench
===================================

Name: des_round_engine

Overview:
- Iterative 16-round DES core: one Feistel round per clock, plus an internal key schedule.
- Sits between the initial-permutation stage and the final-permutation stage of the lab1 DES datapath.
- Accepts the IP-permuted block L0||R0 and a 64-bit key.
- Produces the pre-output R16||L16, which feeds the final permutation directly.
- Encrypt and decrypt are selected per transaction.

Parameters:
- ROUNDS, 16, number of Feistel rounds; fixed at 16 for DES compliance, exposed only for bench reduced-round checks.

Ports:
- wClk  input  1  rising-edge clock
- wReset  input  1  synchronous active-high reset
- wInValid  input  1  request valid
- rInReady  output  1  engine idle, can accept a request
- wDecrypt  input  1  1 = decrypt schedule, 0 = encrypt; sampled on accept
- wInputData  input  [64:1]  L0||R0 after IP; bit 1 = DES bit 1 (MSB)
- wKey  input  [64:1]  DES key incl. parity bits (8,16,...,64 ignored); sampled on accept
- rOutValid  output  1  result valid
- wOutReady  input  1  downstream accepts result
- rOutputData  output  [64:1]  R16||L16 pre-output

Behaviour:
- Reset (sync, wReset=1 at a clock edge):
  - State IDLE, round counter 0.
  - rInReady=1, rOutValid=0, rOutputData=0, internal L/R/C/D=0.
  - Reset mid-operation discards the in-flight block; no partial output.
- States: IDLE, ROUND, DONE.
- IDLE:
  - rInReady=1.
  - On wInValid&&rInReady at an edge, load L=wInputData[1:32], R=wInputData[33:64], C||D=PC1(wKey), latch wDecrypt, counter=1, go to ROUND.
  - Inputs outside the accept edge are ignored.
- ROUND:
  - rInReady=0.
  - Each edge: L<=R, R<=L^f(R,Kn), where Kn=PC2(C'||D') and C',D' are this round's rotated halves. Register C',D'. Counter++.
  - Encrypt: left rotations 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decrypt: right rotations 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - After the round-ROUNDS edge: go to DONE, rOutputData<=R||L (final swap), rOutValid<=1.
- Latency: rOutValid is high in the cycle following the 16th edge after the accept edge (16 cycles accept-to-valid).
- f function: E-expansion 32->48, XOR Kn, S1..S8 (6->4 each), P permutation.
  - S-box row = outer bits b1,b6; column = b2..b5.
- DONE:
  - rOutValid=1; rOutputData held stable until wOutReady=1 at an edge.
  - Then rOutValid<=0, go to IDLE.
  - No accept in DONE (rInReady=0), so there is no same-cycle pass-through; the next accept is possible one cycle after release.
- wInValid held while busy is not lost: it is accepted on the first IDLE cycle.
- wOutReady while not in DONE has no effect.
- Back-to-back throughput: one block per 18 cycles with wOutReady tied high.

Optional Feature:
- Macro: DES_UNROLL2_EN.
- Defined:
  - Two cascaded f/round stages per clock.
  - The key schedule computes two rotation steps per clock using the same rotation tables.
  - Counter advances by 2; DONE after 8 round edges (8 cycles accept-to-valid).
  - ROUNDS must be even.
- Undefined: one round per clock as above.
- Handshake and reset behaviour are identical either way.

Decomposition:
- Package des_pkg holds:
  - E, P, PC1, PC2 index tables.
  - S1..S8 tables.
  - Encrypt/decrypt rotation-amount constants.
  - State enum {IDLE, ROUND, DONE}.
- One combinational sub-module, des_f_function (R[32], K[48] -> [32]), instantiated once (twice under DES_UNROLL2_EN).
- Key schedule and FSM stay in des_round_engine.

Test Plan:
- Encrypt vector: key 133457799BBCDFF1, wInputData CC00CCFFF0AAF0AA, wDecrypt=0 -> rOutputData=0A4CD99543423234 exactly 16 cycles after accept; rInReady=0 throughout.
- Decrypt vector: same key, wInputData 0A4CD99543423234, wDecrypt=1 -> rOutputData=CC00CCFFF0AAF0AA.
- Backpressure: hold wOutReady=0 for 10 cycles after valid -> rOutValid and rOutputData stable; wInValid asserted meanwhile is not accepted until one cycle after release.
- Reset at round 7 -> next cycle rOutValid=0, rInReady=1, rOutputData=0; a fresh request then produces the correct vector-1 result.
- Parity independence: key 123457799ABCDFF0 (parity bits toggled from vector 1) -> same result as vector 1.
- Random encrypt-then-decrypt round trip (1000 blocks, random keys) -> decrypt output equals the original wInputData; repeat with DES_UNROLL2_EN and check 8-cycle latency.

Source files
------------

// File: rtl/des_pkg.sv
// DES constant tables (E, P, PC1, PC2, S-boxes, rotation schedules) and the bit-level helpers built on them.
// All vectors use DES numbering: bit 1 is the leftmost (MSB) bit.
package des_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam int E_TAB [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Decrypt walks the schedule backwards, so its first step is a zero rotation.
    localparam int ENC_ROT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int DEC_ROT [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Row-major: entry index = row*16 + column.
    localparam int SBOX [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
    };

    function automatic logic [1:56] pc1(input logic [1:64] key);
        logic [1:56] o;
        for (int i = 0; i < 56; i++) o[i+1] = key[PC1_TAB[i]];
        return o;
    endfunction

    function automatic logic [1:48] pc2(input logic [1:56] cd);
        logic [1:48] o;
        for (int i = 0; i < 48; i++) o[i+1] = cd[PC2_TAB[i]];
        return o;
    endfunction

    function automatic logic [1:48] expand(input logic [1:32] r);
        logic [1:48] o;
        for (int i = 0; i < 48; i++) o[i+1] = r[E_TAB[i]];
        return o;
    endfunction

    function automatic logic [1:32] permute_p(input logic [1:32] s);
        logic [1:32] o;
        for (int i = 0; i < 32; i++) o[i+1] = s[P_TAB[i]];
        return o;
    endfunction

    // Outer bits b1,b6 pick the row, inner bits b2..b5 the column.
    function automatic logic [3:0] sbox_lookup(input logic [2:0] n, input logic [1:6] b);
        logic [5:0] idx;
        idx = {b[1], b[6], b[2:5]};
        return 4'(SBOX[n][idx]);
    endfunction

    function automatic logic [1:0] rot_step(input logic [3:0] idx, input logic decrypt);
        return decrypt ? 2'(DEC_ROT[idx]) : 2'(ENC_ROT[idx]);
    endfunction

    function automatic logic [1:28] rotate_half(input logic [1:28] x, input logic [1:0] amt,
                                                input logic right);
        logic [1:28] o;
        o = x;
        if (!right) begin
            if (amt == 2'd1) o = {x[2:28], x[1]};
            else if (amt == 2'd2) o = {x[3:28], x[1:2]};
        end else begin
            if (amt == 2'd1) o = {x[28], x[1:27]};
            else if (amt == 2'd2) o = {x[27:28], x[1:26]};
        end
        return o;
    endfunction

endpackage

// File: rtl/des_f_function.sv
// DES Feistel f function: E-expansion, key mix, S1..S8 substitution, P permutation (pure combinational).
module des_f_function
    import des_pkg::*;
(
    input  logic [1:32] r,
    input  logic [1:48] k,
    output logic [1:32] f
);

    logic [1:48] mixed;
    logic [1:32] sbox_out;

    always_comb begin
        mixed    = expand(r) ^ k;
        sbox_out = '0;
        for (int i = 0; i < 8; i++) begin
            sbox_out[4*i+1 +: 4] = sbox_lookup(3'(i), mixed[6*i+1 +: 6]);
        end
        f = permute_p(sbox_out);
    end

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES round engine with on-the-fly key schedule; takes L0||R0 after IP, returns R16||L16.
// Define DES_UNROLL2_EN to run two Feistel rounds per clock (ROUNDS must then be even).
module des_round_engine
    import des_pkg::*;
#(
    parameter int ROUNDS = 16
) (
    input  logic        wClk,
    input  logic        wReset,
    input  logic        wInValid,
    output logic        rInReady,
    input  logic        wDecrypt,
    input  logic [1:64] wInputData,
    input  logic [1:64] wKey,
    output logic        rOutValid,
    input  logic        wOutReady,
    output logic [1:64] rOutputData
);

`ifdef DES_UNROLL2_EN
    localparam logic [4:0] STEP = 5'd2;
`else
    localparam logic [4:0] STEP = 5'd1;
`endif
    // Counter value of the first round in the final clock's batch of rounds.
    localparam logic [4:0] LAST_CNT = 5'(ROUNDS) - STEP + 5'd1;

    state_t      state;
    state_t      next_state;
    logic [1:32] l;
    logic [1:32] r;
    logic [1:28] c;
    logic [1:28] d;
    logic        decrypt;
    logic [4:0]  cnt;
    logic        last_round;

    logic [1:28] c_a;
    logic [1:28] d_a;
    logic [1:48] key_a;
    logic [1:32] f_a;
    logic [1:32] l_nxt;
    logic [1:32] r_nxt;
    logic [1:28] c_nxt;
    logic [1:28] d_nxt;

    always_comb begin
        c_a   = rotate_half(c, rot_step(4'(cnt - 5'd1), decrypt), decrypt);
        d_a   = rotate_half(d, rot_step(4'(cnt - 5'd1), decrypt), decrypt);
        key_a = pc2({c_a, d_a});
    end

    des_f_function u_f_a (
        .r (r),
        .k (key_a),
        .f (f_a)
    );

`ifdef DES_UNROLL2_EN
    logic [1:32] r_mid;
    logic [1:28] c_b;
    logic [1:28] d_b;
    logic [1:48] key_b;
    logic [1:32] f_b;

    // Second round of the pair works on the first round's outputs and the next schedule step.
    always_comb begin
        r_mid = l ^ f_a;
        c_b   = rotate_half(c_a, rot_step(4'(cnt), decrypt), decrypt);
        d_b   = rotate_half(d_a, rot_step(4'(cnt), decrypt), decrypt);
        key_b = pc2({c_b, d_b});
    end

    des_f_function u_f_b (
        .r (r_mid),
        .k (key_b),
        .f (f_b)
    );

    always_comb begin
        l_nxt = r_mid;
        r_nxt = r ^ f_b;
        c_nxt = c_b;
        d_nxt = d_b;
    end
`else
    always_comb begin
        l_nxt = r;
        r_nxt = l ^ f_a;
        c_nxt = c_a;
        d_nxt = d_a;
    end
`endif

    assign last_round = (state == ROUND) && (cnt == LAST_CNT);
    assign rInReady   = (state == IDLE);
    assign rOutValid  = (state == DONE);

    always_ff @(posedge wClk) begin
        if (wReset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (wInValid)   next_state = ROUND;
            ROUND:   if (last_round) next_state = DONE;
            DONE:    if (wOutReady)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge wClk) begin
        if (wReset) begin
            l           <= '0;
            r           <= '0;
            c           <= '0;
            d           <= '0;
            decrypt     <= 1'b0;
            cnt         <= '0;
            rOutputData <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wInValid) begin
                        l        <= wInputData[1:32];
                        r        <= wInputData[33:64];
                        {c, d}   <= pc1(wKey);
                        decrypt  <= wDecrypt;
                        cnt      <= 5'd1;
                    end
                end
                ROUND: begin
                    l   <= l_nxt;
                    r   <= r_nxt;
                    c   <= c_nxt;
                    d   <= d_nxt;
                    cnt <= cnt + STEP;
                    // Final swap: the pre-output is R16||L16.
                    if (last_round) rOutputData <= {r_nxt, l_nxt};
                end
                DONE: begin
                    if (wOutReady) cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_des_round_engine.sv
// Directed bench for des_round_engine: known DES vectors, handshake, backpressure, reset and round trips.
// Build with DES_UNROLL2_EN defined to exercise the two-rounds-per-clock variant.
module tb_des_round_engine;

`ifdef DES_UNROLL2_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 16;
`endif

    localparam logic [63:0] KEY1   = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY1P  = 64'h123457799ABCDFF0;
    localparam logic [63:0] PLAIN1 = 64'hCC00CCFFF0AAF0AA;
    localparam logic [63:0] CIPH1  = 64'h0A4CD99543423234;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        decrypt;
    logic [63:0] in_data;
    logic [63:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] res;
    logic [63:0] held;
    logic [63:0] rk;
    logic [63:0] rp;
    logic [63:0] rc;
    bit          stable_ok;

    always #5 clk = ~clk;

    des_round_engine #(.ROUNDS(16)) dut (
        .wClk        (clk),
        .wReset      (rst),
        .wInValid    (in_valid),
        .rInReady    (in_ready),
        .wDecrypt    (decrypt),
        .wInputData  (in_data),
        .wKey        (key),
        .rOutValid   (out_valid),
        .wOutReady   (out_ready),
        .rOutputData (out_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one request at a negedge; the following posedge accepts it.
    task automatic accept(input string tag, input logic [63:0] k, input logic [63:0] d,
                          input logic dec);
        check({tag, "_ready_before"}, {63'd0, in_ready}, 64'd1);
        key      = k;
        in_data  = d;
        decrypt  = dec;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        key      = $urandom;
        in_data  = {$urandom, $urandom};
        decrypt  = ~dec;
        check({tag, "_ready_drop"}, {63'd0, in_ready}, 64'd0);
    endtask

    // Counts cycles from the accept edge until the result appears (bounded).
    task automatic wait_result(input string tag, output logic [63:0] result);
        int cycles;
        bit busy_ok;
        cycles  = 0;
        busy_ok = 1'b1;
        while (out_valid !== 1'b1 && cycles < 40) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
            cycles++;
        end
        result = out_data;
        check({tag, "_latency"}, 64'(cycles), 64'(LAT));
        check({tag, "_busy_not_ready"}, {63'd0, busy_ok & ~in_ready}, 64'd1);
    endtask

    task automatic finish_result(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_cleared"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_ready_back"}, {63'd0, in_ready}, 64'd1);
    endtask

    task automatic run_block(input string tag, input logic [63:0] k, input logic [63:0] d,
                             input logic dec, output logic [63:0] result);
        accept(tag, k, d, dec);
        wait_result(tag, result);
        finish_result(tag);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        decrypt   = 1'b0;
        in_data   = '0;
        key       = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", {63'd0, in_ready}, 64'd1);
        check("reset_valid", {63'd0, out_valid}, 64'd0);
        check("reset_data", out_data, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Known encrypt and decrypt vectors.
        run_block("enc1", KEY1, PLAIN1, 1'b0, res);
        check("enc1_data", res, CIPH1);
        run_block("dec1", KEY1, CIPH1, 1'b1, res);
        check("dec1_data", res, PLAIN1);

        // Backpressure: result held, queued request waits for release.
        accept("bp", KEY1, PLAIN1, 1'b0);
        wait_result("bp", held);
        check("bp_data", held, CIPH1);
        key       = KEY1;
        in_data   = CIPH1;
        decrypt   = 1'b1;
        in_valid  = 1'b1;
        stable_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) stable_ok = 1'b0;
        end
        check("bp_hold_stable", {63'd0, stable_ok}, 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_valid", {63'd0, out_valid}, 64'd0);
        check("bp_not_yet_accepted", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_accepted_after_release", {63'd0, in_ready}, 64'd0);
        wait_result("bp_dec", res);
        check("bp_dec_data", res, PLAIN1);
        finish_result("bp_dec");

        // Reset while round 7 is being computed.
        accept("rst7", KEY1, PLAIN1, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst7_valid", {63'd0, out_valid}, 64'd0);
        check("rst7_ready", {63'd0, in_ready}, 64'd1);
        check("rst7_data", out_data, 64'd0);
        run_block("post_rst", KEY1, PLAIN1, 1'b0, res);
        check("post_rst_data", res, CIPH1);

        // Parity bits of the key must not matter.
        run_block("parity", KEY1P, PLAIN1, 1'b0, res);
        check("parity_data", res, CIPH1);

        // Random encrypt-then-decrypt round trips.
        for (int i = 0; i < 1000; i++) begin
            rk = {$urandom, $urandom};
            rp = {$urandom, $urandom};
            run_block("rt_enc", rk, rp, 1'b0, rc);
            run_block("rt_dec", rk, rc, 1'b1, res);
            check("rt_roundtrip", res, rp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
